uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_fifo_if.sv | 33 +++
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_tx_fifo.sv | 127 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Holds the FSM state encoding, parity modes and baud divisor math.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// FIFO-side and line-side handshake bundle of the UART transmitter.
// master drives the FIFO flags/data, slave is the transmitter.
interface uart_tx_fifo_if;

  logic       enable;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       frame_done;

  modport master (
    output enable,
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en,
    input  tx,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  enable,
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en,
    output tx,
    output busy,
    output frame_done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: held at zero by restart, ticks on the last
// clock of every bit so boundaries stay locked to the start bit.
module uart_baud_gen #(
  parameter int CPB = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_tick
);

  localparam int W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [W-1:0] LAST = W'(CPB - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bit_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter that pulls bytes from a registered-read FIFO and
// serialises them as start / data / optional parity / stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input logic           clk,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  state_t state_q;
  state_t state_d;

  logic [DATA_BITS-1:0] shreg_q;
  logic [2:0]           bit_idx_q;
  logic                 stop_idx_q;
  logic                 par_q;
  logic                 tick;
  logic                 restart;
  logic                 tx_d;

  // Counter only runs inside a frame, so START always begins at zero.
  assign restart = !(state_q inside {ST_START, ST_DATA,
                                     ST_PARITY, ST_STOP});

  uart_baud_gen #(
    .CPB (CPB)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .bit_tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.enable && !bus.fifo_empty) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_START;
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick && bit_idx_q == LAST_BIT) begin
          state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick && stop_idx_q == LAST_STOP) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
    end else begin
      if (state_q == ST_LOAD) begin
        shreg_q    <= bus.fifo_data[DATA_BITS-1:0];
        par_q      <= (^bus.fifo_data[DATA_BITS-1:0])
                    ^ (PARITY == PAR_ODD);
        bit_idx_q  <= '0;
        stop_idx_q <= 1'b0;
      end
      if (state_q == ST_DATA && tick) begin
        shreg_q   <= shreg_q >> 1;
        bit_idx_q <= bit_idx_q + 3'd1;
      end
      if (state_q == ST_STOP && tick) begin
        stop_idx_q <= stop_idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_q[0];
      ST_PARITY: tx_d = par_q;
      default:   tx_d = 1'b1;
    endcase
  end

  assign bus.tx         = tx_d;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.fifo_rd_en = (state_q == ST_FETCH);
  assign bus.frame_done = (state_q == ST_STOP) && tick
                        && (stop_idx_q == LAST_STOP);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four parameter sets, FIFO models and a
// byte scoreboard that checks every bit period on the line.
module tb_uart_tx_fifo;

  localparam int CPB = 10;

  logic clk;
  logic reset;

  uart_tx_fifo_if b0 ();
  uart_tx_fifo_if b1 ();
  uart_tx_fifo_if b2 ();
  uart_tx_fifo_if b3 ();

  uart_tx_fifo #(
    .CLK_FREQ (1_000_000), .BAUD (100_000), .DATA_BITS (8),
    .PARITY (0), .STOP_BITS (1)
  ) dut0 (.clk (clk), .reset (reset), .bus (b0));

  uart_tx_fifo #(
    .CLK_FREQ (1_000_000), .BAUD (100_000), .DATA_BITS (8),
    .PARITY (2), .STOP_BITS (1)
  ) dut1 (.clk (clk), .reset (reset), .bus (b1));

  uart_tx_fifo #(
    .CLK_FREQ (1_000_000), .BAUD (100_000), .DATA_BITS (8),
    .PARITY (1), .STOP_BITS (1)
  ) dut2 (.clk (clk), .reset (reset), .bus (b2));

  uart_tx_fifo #(
    .CLK_FREQ (1_000_000), .BAUD (100_000), .DATA_BITS (8),
    .PARITY (0), .STOP_BITS (2)
  ) dut3 (.clk (clk), .reset (reset), .bus (b3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] mem [4][16];
  int         wr [4];
  logic       en [4];
  int         rd0, rd1, rd2, rd3;
  logic [7:0] exp_q [$];
  int         sel;
  int         total, bad;
  int         rd_cnt, done_cnt, under_cnt;

  assign b0.enable = en[0];
  assign b1.enable = en[1];
  assign b2.enable = en[2];
  assign b3.enable = en[3];
  assign b0.fifo_empty = (rd0 == wr[0]);
  assign b1.fifo_empty = (rd1 == wr[1]);
  assign b2.fifo_empty = (rd2 == wr[2]);
  assign b3.fifo_empty = (rd3 == wr[3]);

  initial begin
    rd0 = 0; rd1 = 0; rd2 = 0; rd3 = 0;
  end

  always @(posedge clk) if (b0.fifo_rd_en) begin
    b0.fifo_data <= mem[0][rd0[3:0]];
    rd0 <= rd0 + 1;
  end
  always @(posedge clk) if (b1.fifo_rd_en) begin
    b1.fifo_data <= mem[1][rd1[3:0]];
    rd1 <= rd1 + 1;
  end
  always @(posedge clk) if (b2.fifo_rd_en) begin
    b2.fifo_data <= mem[2][rd2[3:0]];
    rd2 <= rd2 + 1;
  end
  always @(posedge clk) if (b3.fifo_rd_en) begin
    b3.fifo_data <= mem[3][rd3[3:0]];
    rd3 <= rd3 + 1;
  end

  logic m_tx, m_busy, m_rd, m_done, m_empty;

  always_comb begin
    m_tx = b0.tx; m_busy = b0.busy; m_rd = b0.fifo_rd_en;
    m_done = b0.frame_done; m_empty = b0.fifo_empty;
    case (sel)
      1: begin
        m_tx = b1.tx; m_busy = b1.busy; m_rd = b1.fifo_rd_en;
        m_done = b1.frame_done; m_empty = b1.fifo_empty;
      end
      2: begin
        m_tx = b2.tx; m_busy = b2.busy; m_rd = b2.fifo_rd_en;
        m_done = b2.frame_done; m_empty = b2.fifo_empty;
      end
      3: begin
        m_tx = b3.tx; m_busy = b3.busy; m_rd = b3.fifo_rd_en;
        m_done = b3.frame_done; m_empty = b3.fifo_empty;
      end
      default: ;
    endcase
  end

  initial begin
    rd_cnt = 0; done_cnt = 0; under_cnt = 0;
  end

  always @(negedge clk) begin
    if (m_rd) rd_cnt <= rd_cnt + 1;
    if (m_done) done_cnt <= done_cnt + 1;
    if ((b0.fifo_rd_en && b0.fifo_empty) ||
        (b1.fifo_rd_en && b1.fifo_empty) ||
        (b2.fifo_rd_en && b2.fifo_empty) ||
        (b3.fifo_rd_en && b3.fifo_empty))
      under_cnt <= under_cnt + 1;
  end

  function automatic int par_of(input int s);
    return (s == 1) ? 2 : (s == 2) ? 1 : 0;
  endfunction

  function automatic int stop_of(input int s);
    return (s == 3) ? 2 : 1;
  endfunction

  task automatic push(input logic [7:0] v);
    mem[sel][wr[sel][3:0]] = v;
    wr[sel] = wr[sel] + 1;
    exp_q.push_back(v);
  endtask

  task automatic check_frame(input string name, input int drop_bit);
    logic       bits [$];
    logic [7:0] d;
    logic       ok_tx, ok_aux, got;
    int         n, nb;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard empty got=0 expected>0", name);
      return;
    end
    d = exp_q.pop_front();
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (par_of(sel) != 0)
      bits.push_back((^d) ^ (par_of(sel) == 1));
    for (int i = 0; i < stop_of(sel); i++) bits.push_back(1'b1);
    n = 0;
    while (m_tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (m_tx !== 1'b0) begin
      bad++;
      $display("FAIL %s start timeout tx=%b expected 0", name, m_tx);
      return;
    end
    nb = bits.size();
    for (int b = 0; b < nb; b++) begin
      ok_tx = 1'b1; ok_aux = 1'b1; got = bits[b];
      for (int c = 0; c < CPB; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (b == drop_bit && c == 5) en[sel] = 1'b0;
        if (m_tx !== bits[b]) begin
          ok_tx = 1'b0; got = m_tx;
        end
        if (m_busy !== 1'b1 ||
            m_done !== (b == nb - 1 && c == CPB - 1))
          ok_aux = 1'b0;
      end
      total++;
      if (!ok_tx) begin
        bad++;
        $display("FAIL %s bit%0d tx got=%b expected=%b",
                 name, b, got, bits[b]);
      end
      total++;
      if (!ok_aux) begin
        bad++;
        $display("FAIL %s bit%0d busy/done got=%b/%b expected=1/%b",
                 name, b, m_busy, m_done, (b == nb - 1));
      end
    end
  endtask

  task automatic quiet_check(input string name, input int cycles);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (m_tx !== 1'b1 || m_busy !== 1'b0 || m_rd !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s idle line got tx=%b busy=%b expected 1/0",
               name, m_tx, m_busy);
    end
  endtask

  task automatic test_reset;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      total++;
      if (m_tx !== 1'b1 || m_busy !== 1'b0 ||
          m_rd !== 1'b0 || m_done !== 1'b0) begin
        bad++;
        $display("FAIL reset dut%0d got tx=%b busy=%b rd=%b done=%b expected 1000",
                 s, m_tx, m_busy, m_rd, m_done);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single;
    int r0, d0;
    sel = 0;
    @(negedge clk);
    r0 = rd_cnt; d0 = done_cnt;
    en[0] = 1'b1;
    push(8'h55);
    check_frame("single_55", -1);
    en[0] = 1'b0;
    quiet_check("single_after", 5);
    total++;
    if (rd_cnt - r0 != 1 || done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL single pulses got rd=%0d done=%0d expected 1/1",
               rd_cnt - r0, done_cnt - d0);
    end
  endtask

  task automatic test_parity;
    for (int s = 1; s <= 2; s++) begin
      sel = s;
      @(negedge clk);
      en[s] = 1'b1;
      push(8'h07);
      check_frame((s == 1) ? "even_07" : "odd_07", -1);
      en[s] = 1'b0;
      quiet_check("parity_after", 5);
    end
  endtask

  task automatic test_back_to_back;
    int r0, gap;
    sel = 0;
    @(negedge clk);
    r0 = rd_cnt;
    en[0] = 1'b1;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    for (int f = 0; f < 3; f++) begin
      check_frame("b2b", -1);
      if (f < 2) begin
        gap = 0;
        while (gap < 50) begin
          @(negedge clk);
          if (m_tx === 1'b0) break;
          gap++;
        end
        total++;
        if (gap != 3) begin
          bad++;
          $display("FAIL b2b gap%0d got=%0d expected=3", f, gap);
        end
      end
    end
    quiet_check("b2b_after", 10);
    en[0] = 1'b0;
    total++;
    if (rd_cnt - r0 != 3) begin
      bad++;
      $display("FAIL b2b rd pulses got=%0d expected=3", rd_cnt - r0);
    end
  endtask

  task automatic test_enable_drop;
    int r0;
    sel = 0;
    @(negedge clk);
    r0 = rd_cnt;
    en[0] = 1'b1;
    push(8'h11);
    push(8'h22);
    check_frame("drop_11", 2);
    quiet_check("drop_after", 40);
    total++;
    if (rd_cnt - r0 != 1) begin
      bad++;
      $display("FAIL drop rd pulses got=%0d expected=1", rd_cnt - r0);
    end
    en[0] = 1'b1;
    check_frame("resume_22", -1);
    en[0] = 1'b0;
    quiet_check("resume_after", 5);
  endtask

  task automatic test_reset_mid;
    int r0, n;
    logic [7:0] dropped;
    sel = 0;
    @(negedge clk);
    en[0] = 1'b1;
    push(8'h00);
    n = 0;
    while (m_tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (35) @(negedge clk);
    total++;
    if (m_tx !== 1'b0 || m_busy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid pre got tx=%b busy=%b expected 0/1",
               m_tx, m_busy);
    end
    reset = 1'b1;
    #1;
    total++;
    if (m_tx !== 1'b1 || m_busy !== 1'b0 || m_rd !== 1'b0) begin
      bad++;
      $display("FAIL rstmid async got tx=%b busy=%b rd=%b expected 1/0/0",
               m_tx, m_busy, m_rd);
    end
    dropped = exp_q.pop_front();
    @(negedge clk);
    reset = 1'b0;
    r0 = rd_cnt;
    quiet_check("rstmid_after", 40);
    total++;
    if (rd_cnt - r0 != 0) begin
      bad++;
      $display("FAIL rstmid reread of %h got=%0d expected=0",
               dropped, rd_cnt - r0);
    end
    en[0] = 1'b0;
  endtask

  task automatic test_stop2;
    int d0;
    sel = 3;
    @(negedge clk);
    d0 = done_cnt;
    en[3] = 1'b1;
    push(8'hFF);
    check_frame("stop2_ff", -1);
    en[3] = 1'b0;
    quiet_check("stop2_after", 5);
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL stop2 done got=%0d expected=1", done_cnt - d0);
    end
  endtask

  initial begin
    total = 0; bad = 0; sel = 0;
    reset = 1'b1;
    for (int s = 0; s < 4; s++) begin
      en[s] = 1'b0;
      wr[s] = 0;
    end
    test_reset;
    test_single;
    test_parity;
    test_back_to_back;
    test_enable_drop;
    test_reset_mid;
    test_stop2;
    total++;
    if (exp_q.size() != 0 || under_cnt != 0) begin
      bad++;
      $display("FAIL final leftover=%0d underflow=%0d expected 0/0",
               exp_q.size(), under_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
